// File: rtl/mul_datapath.sv
// Shift-add multiplier datapath. It answers the multiplier controller's
// store/shift/add commands and returns the current low product bit as lsb.
// It holds the multiplicand and a carry+product register that is one bit wider
// than the product. When the controller signals ready after the last shift, it
// captures the final product.
module mul_datapath #(
  parameter int         WIDTH  = 32,
  parameter logic [5:0] ADD_FN = 6'b100000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_run,
  input  logic [WIDTH-1:0]     i_mcand,
  input  logic [WIDTH-1:0]     i_mplier,
  input  logic                 i_strctrl,
  input  logic                 i_wrctrl,
  input  logic [5:0]           i_addctrl,
  input  logic                 i_ready,
  output logic                 o_lsb,
  output logic                 o_busy,
  output logic [2*WIDTH-1:0]   o_product,
  output logic                 o_valid
);

  localparam int                CNT_W   = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WIDTH);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_mcand;
  logic [2*WIDTH:0]      r_prod;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*WIDTH-1:0]    r_product;
  logic                  r_valid;

  logic [WIDTH-1:0]      w_addend;
  logic [WIDTH:0]        w_sum;
  logic [2*WIDTH:0]      w_stored;
  logic                  w_done;

  // Shift counter never wraps. Once all WIDTH shifts have happened, extra
  // controller commands must not disturb the finished product.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Adder: upper product half plus either the multiplicand or zero, with carry out.
  always_comb begin
    w_addend = (i_addctrl == ADD_FN) ? r_mcand : '0;
    w_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    w_stored = {w_sum, r_prod[WIDTH-1:0]};
    w_done   = (r_cnt == CNT_MAX);
  end

  // Control state, operand load, add/shift steps and result capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_prod    <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_mcand <= i_mcand;
            r_prod  <= {1'b0, {WIDTH{1'b0}}, i_mplier};
            r_cnt   <= '0;
            r_state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (!w_done) begin
            if (i_strctrl && i_wrctrl) begin
              // Store the sum, then shift, in one edge. The carry moves into the top of the product.
              r_prod <= w_stored >> 1;
              r_cnt  <= cnt_sat_inc(r_cnt);
            end else if (i_wrctrl) begin
              r_prod <= r_prod >> 1;
              r_cnt  <= cnt_sat_inc(r_cnt);
            end else if (i_strctrl) begin
              r_prod[2*WIDTH:WIDTH] <= w_sum;
            end
          end
          if (i_ready && w_done) begin
            r_product <= r_prod[2*WIDTH-1:0];
            r_valid   <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_lsb     = r_prod[0];
  assign o_busy    = (r_state == S_ACTIVE);
  assign o_product = r_product;
  assign o_valid   = r_valid;

endmodule

// File: tb/tb_mul_datapath.sv
// Testbench for mul_datapath. The bench plays the controller itself, with one
// store+shift per cycle and add selected by lsb. Expected products are queued
// when run is driven and checked when valid pulses.
module tb_mul_datapath;

  localparam int         WIDTH  = 32;
  localparam logic [5:0] ADD_FN = 6'b100000;

  logic               clk = 1'b0;
  logic               rst, run, strctrl, wrctrl, ready;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [5:0]         addctrl;
  logic               lsb, busy, valid;
  logic [2*WIDTH-1:0] product;

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  logic [63:0] sb[$];

  typedef struct {
    logic [31:0] mc;
    logic [31:0] mp;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  mul_datapath #(.WIDTH(WIDTH), .ADD_FN(ADD_FN)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_mcand(mcand), .i_mplier(mplier),
    .i_strctrl(strctrl), .i_wrctrl(wrctrl), .i_addctrl(addctrl), .i_ready(ready),
    .o_lsb(lsb), .o_busy(busy), .o_product(product), .o_valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid pulse must match the oldest queued product.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) chk("unexpected_valid", 64'(product), 64'hDEAD_0000_0000_DEAD);
      else chk("sb_product", 64'(product), sb.pop_front());
    end
  end

  task automatic ctrl_idle();
    strctrl = 1'b0; wrctrl = 1'b0; addctrl = 6'd0; ready = 1'b0;
  endtask

  // One full multiply with the controller in the loop. If intr_at >= 0, a run
  // with other operands is driven at that shift cycle.
  task automatic run_mult(input logic [31:0] mc, input logic [31:0] mp,
                          input int intr_at, input logic [63:0] exp);
    int adds = 0;
    int nv0;
    mcand = mc; mplier = mp; run = 1'b1;
    sb.push_back(exp);
    tick();
    run = 1'b0;
    chk("busy_after_run", 64'(busy), 64'd1);
    chk("lsb_after_load", 64'(lsb), 64'(mp[0]));
    for (int i = 0; i < WIDTH; i++) begin
      if (i == intr_at) begin
        run = 1'b1; mcand = ~mc; mplier = mp ^ 32'h0000_0005;
      end
      if (lsb) adds++;
      strctrl = 1'b1; wrctrl = 1'b1;
      addctrl = lsb ? ADD_FN : 6'd0;
      tick();
      run = 1'b0;
    end
    ctrl_idle();
    chk("add_steps", 64'(adds), 64'($countones(mp)));
    nv0 = n_valid;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("busy_at_capture", 64'(busy), 64'd0);
    chk("valid_at_capture", 64'(valid), 64'd1);
    chk("product_at_capture", 64'(product), exp);
    tick();
    chk("valid_one_cycle", 64'(valid), 64'd0);
    chk("product_held", 64'(product), exp);
    chk("valid_pulse_count", 64'(n_valid - nv0), 64'd1);
  endtask

  initial begin
    logic lsb32;
    vecs[0] = '{32'd3,         32'd5,         64'd15};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001};
    vecs[2] = '{32'h12345678,  32'd0,         64'd0};
    vecs[3] = '{32'd6,         32'd7,         64'd42};
    vecs[4] = '{32'd2,         32'hFFFFFFFF,  64'h1_FFFFFFFE};
    vecs[5] = '{32'h80000000,  32'h80000000,  64'h40000000_00000000};
    vecs[6] = '{32'h00010000,  32'h00010000,  64'h1_00000000};
    vecs[7] = '{32'hDEADBEEF,  32'd1,         64'h00000000_DEADBEEF};

    rst = 1'b1; run = 1'b0; mcand = '0; mplier = '0;
    ctrl_idle();

    // Reset state
    tick(); tick();
    chk("rst_lsb", 64'(lsb), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    rst = 1'b0;
    tick();

    // Table-driven full multiplies
    for (int v = 0; v < 8; v++) begin
      run_mult(vecs[v].mc, vecs[v].mp, -1, vecs[v].exp);
    end

    // Reset mid-operation discards the partial result and the held product
    mcand = 32'd7; mplier = 32'd9; run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      strctrl = 1'b1; wrctrl = 1'b1; addctrl = lsb ? ADD_FN : 6'd0;
      tick();
    end
    ctrl_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_product", 64'(product), 64'd0);
    chk("midrst_valid", 64'(valid), 64'd0);
    tick();
    run_mult(32'd6, 32'd7, -1, 64'd42);

    // Run while active is ignored
    run_mult(32'd11, 32'd13, 5, 64'd143);

    // Commands in idle are ignored (prod_reg holds 143, lsb=1)
    for (int i = 0; i < 3; i++) begin
      strctrl = 1'b1; wrctrl = 1'b1; addctrl = ADD_FN;
      tick();
    end
    ctrl_idle();
    chk("idle_cmd_lsb", 64'(lsb), 64'd1);
    chk("idle_cmd_busy", 64'(busy), 64'd0);
    chk("idle_cmd_product", 64'(product), 64'd143);

    // Controller over-run: 40 shift pulses and an early ready
    mcand = 32'd2; mplier = 32'hFFFFFFFF; run = 1'b1;
    sb.push_back(64'h1_FFFFFFFE);
    tick();
    run = 1'b0;
    lsb32 = 1'b0;
    for (int p = 1; p <= 40; p++) begin
      strctrl = 1'b1; wrctrl = 1'b1; addctrl = ADD_FN;
      ready = (p == 10);
      tick();
      if (p == 10) begin
        chk("early_ready_valid", 64'(valid), 64'd0);
        chk("early_ready_busy", 64'(busy), 64'd1);
      end
      if (p == 32) lsb32 = lsb;
    end
    ctrl_idle();
    chk("overrun_lsb_frozen", 64'(lsb), 64'(lsb32));
    chk("overrun_busy", 64'(busy), 64'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("overrun_valid", 64'(valid), 64'd1);
    chk("overrun_product", 64'(product), 64'h1_FFFFFFFE);
    tick(); tick();

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
